// File: rtl/cdnsusbhs_dffn_sync_filt_pkg.sv
// Shared constants and elaboration-time helpers for the filtered multi-bit level synchroniser.
package cdnsusbhs_dffn_sync_filt_pkg;

  localparam int CDNSUSBHS_SYNC_MIN_FLOPS = 2;

  function automatic int cdnsusbhs_clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic int filt_width(input int filt_cnt);
    int w;
    w = cdnsusbhs_clog2(filt_cnt);
    return (w < 1) ? 1 : w;
  endfunction

  // Depths below the metastability minimum are silently raised to it.
  function automatic int sync_depth(input int num_flops);
    return (num_flops < CDNSUSBHS_SYNC_MIN_FLOPS) ? CDNSUSBHS_SYNC_MIN_FLOPS : num_flops;
  endfunction

  function automatic int filt_depth(input int filt_cnt);
    return (filt_cnt < 1) ? 1 : filt_cnt;
  endfunction

endpackage

// File: rtl/cdnsusbhs_dffn_sync_filt_ch.sv
// One channel: synchroniser chain, stability counter and registered edge pulses.
module cdnsusbhs_dffn_sync_filt_ch
  import cdnsusbhs_dffn_sync_filt_pkg::*;
#(
  parameter int   NUM_FLOPS = 2,
  parameter logic RST_VAL   = 1'b1,
  parameter int   FILT_CNT  = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tx,
  output logic o_sig,
  output logic o_rise,
  output logic o_fall
);

  localparam int NF     = sync_depth(NUM_FLOPS);
  localparam int FC     = filt_depth(FILT_CNT);
  localparam int FILT_W = filt_width(FC);
  localparam logic [FILT_W-1:0] CNT_MAX = FILT_W'(FC - 1);

  logic [NF-1:0]     r_sync;
  logic [FILT_W-1:0] r_cnt;
  logic              r_sig;
  logic              r_rise;
  logic              r_fall;
  logic              w_s;
  logic              w_diff;
  logic              w_done;

  assign w_s    = r_sync[NF-1];
  assign w_diff = w_s ^ r_sig;
  assign w_done = w_diff & (r_cnt == CNT_MAX);

  // Synchroniser shift chain; bit 0 samples the asynchronous input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {NF{RST_VAL}};
    end else begin
      r_sync <= {r_sync[NF-2:0], i_tx};
    end
  end

  // Stability filter: the level only moves after FC consecutive differing samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sig  <= RST_VAL;
      r_cnt  <= {FILT_W{1'b0}};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (!w_diff) begin
      r_cnt  <= {FILT_W{1'b0}};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (w_done) begin
      r_sig  <= w_s;
      r_cnt  <= {FILT_W{1'b0}};
      r_rise <= w_s;
      r_fall <= ~w_s;
    end else begin
      r_cnt  <= r_cnt + {{(FILT_W-1){1'b0}}, 1'b1};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end
  end

  assign o_sig  = r_sig;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/cdnsusbhs_dffn_sync_filt.sv
// WIDTH independent filtered level synchronisers with rise/fall pulses and a change summary.
module cdnsusbhs_dffn_sync_filt #(
  parameter int               WIDTH     = 4,
  parameter int               NUM_FLOPS = 2,
  parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b1}},
  parameter int               FILT_CNT  = 3
) (
  input  logic             rxclk,
  input  logic             rxrst,
  input  logic [WIDTH-1:0] txsignal,
  output logic [WIDTH-1:0] rxsignal,
  output logic [WIDTH-1:0] rxrise,
  output logic [WIDTH-1:0] rxfall,
  output logic             rxchg
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    cdnsusbhs_dffn_sync_filt_ch #(
      .NUM_FLOPS (NUM_FLOPS),
      .RST_VAL   (RST_VAL[g]),
      .FILT_CNT  (FILT_CNT)
    ) u_ch (
      .i_clk  (rxclk),
      .i_rst  (rxrst),
      .i_tx   (txsignal[g]),
      .o_sig  (rxsignal[g]),
      .o_rise (rxrise[g]),
      .o_fall (rxfall[g])
    );
  end

  // Pulses are already registered, so this summary stays glitch-free.
  assign rxchg = |(rxrise | rxfall);

endmodule

// File: tb/tb_cdnsusbhs_dffn_sync_filt.sv
// Scoreboard bench: stimulus queues hand-computed expectations tagged by edge number; a monitor checks them.
module tb_cdnsusbhs_dffn_sync_filt;

  logic       clk;
  logic       rst_a, rst_b;
  logic [3:0] tx_a, tx_b;
  logic [3:0] sig_a, rise_a, fall_a, sig_b, rise_b, fall_b;
  logic       chg_a, chg_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         at;
    bit         dut;
    logic [3:0] sig;
    logic [3:0] rise;
    logic [3:0] fall;
    string      name;
  } exp_t;

  exp_t q[$];

  cdnsusbhs_dffn_sync_filt u_dut_a (
    .rxclk    (clk),
    .rxrst    (rst_a),
    .txsignal (tx_a),
    .rxsignal (sig_a),
    .rxrise   (rise_a),
    .rxfall   (fall_a),
    .rxchg    (chg_a)
  );

  cdnsusbhs_dffn_sync_filt #(
    .WIDTH     (4),
    .NUM_FLOPS (3),
    .RST_VAL   (4'hF),
    .FILT_CNT  (1)
  ) u_dut_b (
    .rxclk    (clk),
    .rxrst    (rst_b),
    .txsignal (tx_b),
    .rxsignal (sig_b),
    .rxrise   (rise_b),
    .rxfall   (fall_b),
    .rxchg    (chg_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic expect_range(input bit dut, input int from, input int to,
                              input logic [3:0] s, input logic [3:0] r,
                              input logic [3:0] f, input string name);
    for (int k = from; k <= to; k++) begin
      exp_t e;
      e.at = k; e.dut = dut; e.sig = s; e.rise = r; e.fall = f; e.name = name;
      q.push_back(e);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input exp_t e);
    logic [3:0] as, ar, af;
    logic       ac, xc;
    if (e.dut) begin
      as = sig_b; ar = rise_b; af = fall_b; ac = chg_b;
    end else begin
      as = sig_a; ar = rise_a; af = fall_a; ac = chg_a;
    end
    xc = |(e.rise | e.fall);
    n_tests++;
    if (e.at != cyc) begin
      n_fail++;
      $display("FAIL %s (dut %0d): checked at edge %0d, required edge %0d", e.name, e.dut, cyc, e.at);
    end else if (as !== e.sig || ar !== e.rise || af !== e.fall || ac !== xc) begin
      n_fail++;
      $display("FAIL %s (dut %0d) edge %0d: got sig=%h rise=%h fall=%h chg=%b, required sig=%h rise=%h fall=%h chg=%b",
               e.name, e.dut, cyc, as, ar, af, ac, e.sig, e.rise, e.fall, xc);
    end
  endtask

  // Monitor: count edges and retire every expectation due at this edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at <= cyc) begin
        check(q[i]);
        q.delete(i);
      end
    end
  end

  initial begin
    int c;
    // Test 1: reset with inputs opposite to the reset value
    rst_a = 1'b1; tx_a = 4'h0;
    rst_b = 1'b1; tx_b = 4'hF;
    expect_range(1'b0, 1, 2, 4'hF, 4'h0, 4'h0, "reset_a");
    expect_range(1'b1, 1, 2, 4'hF, 4'h0, 4'h0, "reset_b");
    wait_n(2);
    c = cyc;
    rst_a = 1'b0; rst_b = 1'b0;
    expect_range(1'b0, c + 1, c + 4, 4'hF, 4'h0, 4'h0, "post_rst_hold");
    expect_range(1'b0, c + 5, c + 5, 4'h0, 4'h0, 4'hF, "post_rst_fall");
    expect_range(1'b0, c + 6, c + 6, 4'h0, 4'h0, 4'h0, "post_rst_settled");
    expect_range(1'b1, c + 1, c + 8, 4'hF, 4'h0, 4'h0, "b_idle");
    wait_n(7);

    // Test 2: clean rising edge on bit 0
    c = cyc; tx_a = 4'h1;
    expect_range(1'b0, c + 1, c + 4, 4'h0, 4'h0, 4'h0, "rise0_latency");
    expect_range(1'b0, c + 5, c + 5, 4'h1, 4'h1, 4'h0, "rise0_pulse");
    expect_range(1'b0, c + 6, c + 9, 4'h1, 4'h0, 4'h0, "rise0_hold");
    wait_n(10);

    // Test 3a: two-cycle glitch on bit 1 is dropped
    c = cyc; tx_a = 4'h3;
    expect_range(1'b0, c + 1, c + 7, 4'h1, 4'h0, 4'h0, "glitch2_dropped");
    wait_n(2);
    tx_a = 4'h1;
    wait_n(6);

    // Test 3b: three-cycle pulse on bit 1 passes, then falls back
    c = cyc; tx_a = 4'h3;
    expect_range(1'b0, c + 1, c + 4, 4'h1, 4'h0, 4'h0, "pulse3_wait");
    expect_range(1'b0, c + 5, c + 5, 4'h3, 4'h2, 4'h0, "pulse3_rise");
    expect_range(1'b0, c + 6, c + 7, 4'h3, 4'h0, 4'h0, "pulse3_high");
    expect_range(1'b0, c + 8, c + 8, 4'h1, 4'h0, 4'h2, "pulse3_fall");
    expect_range(1'b0, c + 9, c + 9, 4'h1, 4'h0, 4'h0, "pulse3_low");
    wait_n(3);
    tx_a = 4'h1;
    wait_n(7);

    // Test 4: raise bit 3, then bit2 rises while bit3 falls on the same cycle
    c = cyc; tx_a = 4'h9;
    expect_range(1'b0, c + 1, c + 4, 4'h1, 4'h0, 4'h0, "rise3_wait");
    expect_range(1'b0, c + 5, c + 5, 4'h9, 4'h8, 4'h0, "rise3_pulse");
    expect_range(1'b0, c + 6, c + 6, 4'h9, 4'h0, 4'h0, "rise3_hold");
    wait_n(6);
    c = cyc; tx_a = 4'h5;
    expect_range(1'b0, c + 1, c + 4, 4'h9, 4'h0, 4'h0, "simul_wait");
    expect_range(1'b0, c + 5, c + 5, 4'h5, 4'h4, 4'h8, "simul_pulse");
    expect_range(1'b0, c + 6, c + 6, 4'h5, 4'h0, 4'h0, "simul_hold");
    wait_n(6);

    // Test 5: reset in the middle of a filter count
    c = cyc; tx_a = 4'h4;
    expect_range(1'b0, c + 1, c + 3, 4'h5, 4'h0, 4'h0, "midcount_pre");
    wait_n(3);
    c = cyc; rst_a = 1'b1; tx_a = 4'hF;
    expect_range(1'b0, c + 1, c + 2, 4'hF, 4'h0, 4'h0, "midcount_reset");
    wait_n(2);
    c = cyc; rst_a = 1'b0;
    expect_range(1'b0, c + 1, c + 8, 4'hF, 4'h0, 4'h0, "midcount_quiet");
    wait_n(8);
    c = cyc; tx_a = 4'hE;
    expect_range(1'b0, c + 1, c + 4, 4'hF, 4'h0, 4'h0, "fresh_count_wait");
    expect_range(1'b0, c + 5, c + 5, 4'hE, 4'h0, 4'h1, "fresh_count_fall");
    expect_range(1'b0, c + 6, c + 6, 4'hE, 4'h0, 4'h0, "fresh_count_hold");
    wait_n(6);

    // Test 6: unfiltered, 3-deep config passes a one-cycle pulse
    c = cyc; tx_b = 4'hE;
    expect_range(1'b1, c + 1, c + 3, 4'hF, 4'h0, 4'h0, "nofilt_latency");
    expect_range(1'b1, c + 4, c + 4, 4'hE, 4'h0, 4'h1, "nofilt_fall");
    expect_range(1'b1, c + 5, c + 5, 4'hF, 4'h1, 4'h0, "nofilt_rise");
    expect_range(1'b1, c + 6, c + 7, 4'hF, 4'h0, 4'h0, "nofilt_hold");
    wait_n(1);
    tx_b = 4'hF;
    wait_n(8);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s (dut %0d): never checked, required edge %0d", e.name, e.dut, e.at);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
